// File: rtl/seg7_pkg.sv
// Shared segment patterns, character codes and frame-tracking state type
// for the HEX display readback path.
package seg7_pkg;

   // Segment codes are active-low, bit0 = a ... bit6 = g
   localparam logic [6:0] SEG_H     = 7'b0001001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_O     = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] CH_H = 2'd0;
   localparam logic [1:0] CH_E = 2'd1;
   localparam logic [1:0] CH_L = 2'd2;
   localparam logic [1:0] CH_O = 2'd3;

   typedef enum logic {
      WAIT_FIRST,
      IN_FRAME
   } frame_state_e;

endpackage

// File: rtl/seg7_to_char.sv
// Combinational inverse of the character encoder: maps a 7-segment code
// back to its 2-bit character, flagging blank and illegal patterns.
module seg7_to_char
   import seg7_pkg::*;
(
   input  logic [6:0] code_i,
   output logic [1:0] char_o,
   output logic       is_blank_o,
   output logic       is_illegal_o
);

   always_comb begin
      char_o       = CH_H;
      is_blank_o   = 1'b0;
      is_illegal_o = 1'b0;
      case (code_i)
         SEG_H:     char_o = CH_H;
         SEG_E:     char_o = CH_E;
         SEG_L:     char_o = CH_L;
         SEG_O:     char_o = CH_O;
         SEG_BLANK: is_blank_o = 1'b1;
         default:   is_illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, glitch-filters each sample, keeps a
// decoded character per digit and checks that digits arrive in scan order.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 5,
   parameter int STABLE_CNT = 2,
   parameter int IDX_W      = 3
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    scan_valid,
   input  logic [IDX_W-1:0]        scan_digit,
   input  logic [6:0]              scan_code,
   output logic [2*NUM_DIGITS-1:0] char_out,
   output logic [NUM_DIGITS-1:0]   char_valid,
   output logic [NUM_DIGITS-1:0]   blank_out,
   output logic                    code_err,
   output logic                    seq_err,
   output logic                    frame_done
);

   localparam logic [IDX_W:0]   DIGIT_LIMIT = (IDX_W+1)'(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0] FIRST_NEXT  = IDX_W'(1);
   localparam logic [2:0]       STABLE_RUN  = 3'(STABLE_CNT);

   logic [IDX_W-1:0]        last_digit_q, last_digit_d;
   logic [6:0]              last_code_q, last_code_d;
   logic [2:0]              run_q, run_d;
   frame_state_e            state_q, state_d;
   logic [IDX_W-1:0]        expect_q, expect_d;
   logic [2*NUM_DIGITS-1:0] char_q, char_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic                    code_err_q, code_err_d;
   logic                    seq_err_q, seq_err_d;
   logic                    frame_done_q, frame_done_d;

   logic       in_range;
   logic       range_err;
   logic       accept;
   logic       order_err;
   logic [1:0] dec_char;
   logic       dec_blank;
   logic       dec_illegal;

   seg7_to_char u_decode (
      .code_i       (scan_code),
      .char_o       (dec_char),
      .is_blank_o   (dec_blank),
      .is_illegal_o (dec_illegal)
   );

   // A run saturates at STABLE_CNT so a held code is accepted exactly once.
   always_comb begin
      last_digit_d = last_digit_q;
      last_code_d  = last_code_q;
      run_d        = run_q;
      accept       = 1'b0;
      in_range     = ({1'b0, scan_digit} < DIGIT_LIMIT);
      range_err    = scan_valid & ~in_range;
      if (scan_valid && in_range) begin
         if ((scan_digit == last_digit_q) && (scan_code == last_code_q)) begin
            if (run_q != STABLE_RUN) begin
               run_d = run_q + 3'd1;
            end
         end else begin
            last_digit_d = scan_digit;
            last_code_d  = scan_code;
            run_d        = 3'd1;
         end
         if (STABLE_CNT == 1) begin
            accept = 1'b1;
         end else begin
            accept = (run_d == STABLE_RUN) && (run_q != STABLE_RUN);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      expect_d     = expect_q;
      order_err    = 1'b0;
      frame_done_d = 1'b0;
      if (accept) begin
         case (state_q)
            WAIT_FIRST: begin
               if (scan_digit == '0) begin
                  if (LAST_IDX == '0) begin
                     frame_done_d = 1'b1;
                  end else begin
                     state_d  = IN_FRAME;
                     expect_d = FIRST_NEXT;
                  end
               end
            end
            IN_FRAME: begin
               if (scan_digit == expect_q) begin
                  if (scan_digit == LAST_IDX) begin
                     frame_done_d = 1'b1;
                     state_d      = WAIT_FIRST;
                  end else begin
                     expect_d = expect_q + FIRST_NEXT;
                  end
               end else if (scan_digit == '0) begin
                  order_err = 1'b1;
                  expect_d  = FIRST_NEXT;
               end else begin
                  order_err = 1'b1;
                  state_d   = WAIT_FIRST;
               end
            end
            default: state_d = WAIT_FIRST;
         endcase
      end
   end

   // Illegal codes still sequence the frame but never touch digit storage.
   always_comb begin
      char_d     = char_q;
      valid_d    = valid_q;
      blank_d    = blank_q;
      code_err_d = accept & dec_illegal;
      seq_err_d  = range_err | order_err;
      if (accept && !dec_illegal) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_digit == IDX_W'(i)) begin
               if (dec_blank) begin
                  valid_d[i] = 1'b0;
                  blank_d[i] = 1'b1;
               end else begin
                  char_d[2*i +: 2] = dec_char;
                  valid_d[i]       = 1'b1;
                  blank_d[i]       = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_digit_q <= '0;
         last_code_q  <= '0;
         run_q        <= '0;
         state_q      <= WAIT_FIRST;
         expect_q     <= '0;
         char_q       <= '0;
         valid_q      <= '0;
         blank_q      <= '0;
         code_err_q   <= 1'b0;
         seq_err_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         last_digit_q <= last_digit_d;
         last_code_q  <= last_code_d;
         run_q        <= run_d;
         state_q      <= state_d;
         expect_q     <= expect_d;
         char_q       <= char_d;
         valid_q      <= valid_d;
         blank_q      <= blank_d;
         code_err_q   <= code_err_d;
         seq_err_q    <= seq_err_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign char_out   = char_q;
   assign char_valid = valid_q;
   assign blank_out  = blank_q;
   assign code_err   = code_err_q;
   assign seq_err    = seq_err_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random bus traffic,
// all checked every cycle against a streak/frame-position reference model.
module tb_seg7_scan_decoder;

   localparam int N  = 5;
   localparam int S  = 2;
   localparam int IW = 3;

   localparam logic [6:0] C_H   = 7'b0001001;
   localparam logic [6:0] C_E   = 7'b0000110;
   localparam logic [6:0] C_L   = 7'b1000111;
   localparam logic [6:0] C_O   = 7'b1000000;
   localparam logic [6:0] C_BL  = 7'b1111111;
   localparam logic [6:0] C_BAD = 7'b0101010;

   logic          clk = 1'b0;
   logic          resetn = 1'b1;
   logic          scan_valid = 1'b0;
   logic [IW-1:0] scan_digit = '0;
   logic [6:0]    scan_code = '0;
   logic [2*N-1:0] char_out;
   logic [N-1:0]   char_valid;
   logic [N-1:0]   blank_out;
   logic           code_err;
   logic           seq_err;
   logic           frame_done;

   int checks = 0;
   int fails = 0;
   int frameCount = 0;
   bit checkEn = 1'b0;

   int             mLastDigit;
   int             mLastCode;
   int             mStreak;
   int             mNext;
   logic [2*N-1:0] mChar;
   logic [N-1:0]   mValid;
   logic [N-1:0]   mBlank;
   logic           mCodeErr;
   logic           mSeqErr;
   logic           mFrameDone;

   seg7_scan_decoder #(
      .NUM_DIGITS (N),
      .STABLE_CNT (S),
      .IDX_W      (IW)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .scan_valid (scan_valid),
      .scan_digit (scan_digit),
      .scan_code  (scan_code),
      .char_out   (char_out),
      .char_valid (char_valid),
      .blank_out  (blank_out),
      .code_err   (code_err),
      .seq_err    (seq_err),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // kind: 0 legal char, 1 blank, 2 illegal
   function automatic void decodeRef(input logic [6:0] code, output int kind, output logic [1:0] ch);
      kind = 0;
      ch   = 2'd0;
      if (code == C_H) ch = 2'd0;
      else if (code == C_E) ch = 2'd1;
      else if (code == C_L) ch = 2'd2;
      else if (code == C_O) ch = 2'd3;
      else if (code == C_BL) kind = 1;
      else kind = 2;
   endfunction

   task automatic modelClear();
      mLastDigit = -1;
      mLastCode  = -1;
      mStreak    = 0;
      mNext      = -1;
      mChar      = '0;
      mValid     = '0;
      mBlank     = '0;
      mCodeErr   = 1'b0;
      mSeqErr    = 1'b0;
      mFrameDone = 1'b0;
   endtask

   // mNext = -1 means no frame is open; otherwise it is the digit due next.
   task automatic modelStep();
      int kind;
      logic [1:0] ch;
      int dg;
      mCodeErr   = 1'b0;
      mSeqErr    = 1'b0;
      mFrameDone = 1'b0;
      if (!scan_valid) return;
      dg = int'(scan_digit);
      if (dg >= N) begin
         mSeqErr = 1'b1;
         return;
      end
      if (dg == mLastDigit && int'(scan_code) == mLastCode) begin
         mStreak++;
      end else begin
         mLastDigit = dg;
         mLastCode  = int'(scan_code);
         mStreak    = 1;
      end
      if (!(S == 1 || mStreak == S)) return;
      decodeRef(scan_code, kind, ch);
      if (kind == 2) begin
         mCodeErr = 1'b1;
      end else if (kind == 1) begin
         mValid[dg] = 1'b0;
         mBlank[dg] = 1'b1;
      end else begin
         mChar[2*dg +: 2] = ch;
         mValid[dg]       = 1'b1;
         mBlank[dg]       = 1'b0;
      end
      if (mNext < 0) begin
         if (dg == 0) begin
            if (N == 1) mFrameDone = 1'b1;
            else mNext = 1;
         end
      end else if (dg == mNext) begin
         if (dg == N - 1) begin
            mFrameDone = 1'b1;
            mNext      = -1;
         end else begin
            mNext = mNext + 1;
         end
      end else if (dg == 0) begin
         mSeqErr = 1'b1;
         mNext   = 1;
      end else begin
         mSeqErr = 1'b1;
         mNext   = -1;
      end
   endtask

   always @(posedge clk) begin
      if (resetn) modelStep();
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("char_out", 32'(char_out), 32'(mChar));
         checkOutput("char_valid", 32'(char_valid), 32'(mValid));
         checkOutput("blank_out", 32'(blank_out), 32'(mBlank));
         checkOutput("code_err", 32'(code_err), 32'(mCodeErr));
         checkOutput("seq_err", 32'(seq_err), 32'(mSeqErr));
         checkOutput("frame_done", 32'(frame_done), 32'(mFrameDone));
         if (frame_done) frameCount++;
      end
   end

   task automatic applyStimulus(input logic v, input logic [IW-1:0] d, input logic [6:0] c, input int n);
      scan_valid = v;
      scan_digit = d;
      scan_code  = c;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendDigit(input int d, input logic [6:0] c);
      applyStimulus(1'b1, IW'(d), c, S);
   endtask

   initial begin
      logic [6:0] helo [5];
      logic [6:0] helo2 [5];
      int frameBase;
      int d;
      int r;
      int k;
      int hold;
      logic [6:0] code;
      helo[0] = C_H; helo[1] = C_E; helo[2] = C_L; helo[3] = C_L; helo[4] = C_O;
      helo2[0] = C_H; helo2[1] = C_E; helo2[2] = C_L; helo2[3] = C_O; helo2[4] = C_O;

      modelClear();
      #2 resetn = 1'b0;
      #1;
      checkOutput("reset char_out", 32'(char_out), 32'h0);
      checkOutput("reset char_valid", 32'(char_valid), 32'h0);
      @(posedge clk);
      #1 resetn = 1'b1;
      checkEn = 1'b1;

      $display("[TB] scenario: HELLO frame");
      frameBase = frameCount;
      for (int i = 0; i < N; i++) sendDigit(i, helo[i]);
      checkOutput("s1 frame_done pulse", 32'(frame_done), 32'h1);
      applyStimulus(1'b0, '0, '0, 1);
      checkOutput("s1 frame count", 32'(frameCount - frameBase), 32'h1);
      checkOutput("s1 char_out", 32'(char_out), 32'(10'b11_10_10_01_00));
      checkOutput("s1 char_valid", 32'(char_valid), 32'(5'b11111));

      $display("[TB] scenario: glitch on digit 2");
      sendDigit(2, C_O);
      applyStimulus(1'b1, 3'd2, C_E, 1);
      checkOutput("s2 no glitch write", 32'(char_out[5:4]), 32'h3);
      applyStimulus(1'b1, 3'd2, C_L, 2);
      checkOutput("s2 char_out[5:4]", 32'(char_out[5:4]), 32'h2);

      $display("[TB] scenario: illegal code on digit 1");
      applyStimulus(1'b1, 3'd1, C_BAD, 2);
      checkOutput("s3 code_err", 32'(code_err), 32'h1);
      checkOutput("s3 char_out[3:2]", 32'(char_out[3:2]), 32'h1);
      checkOutput("s3 char_valid[1]", 32'(char_valid[1]), 32'h1);
      applyStimulus(1'b1, 3'd1, C_BAD, 1);
      checkOutput("s3 single code_err", 32'(code_err), 32'h0);

      $display("[TB] scenario: out-of-order digits");
      sendDigit(0, C_H);
      sendDigit(1, C_E);
      sendDigit(3, C_O);
      checkOutput("s4 seq_err", 32'(seq_err), 32'h1);
      checkOutput("s4 no frame_done", 32'(frame_done), 32'h0);
      for (int i = 0; i < N; i++) sendDigit(i, helo2[i]);
      checkOutput("s4 frame_done", 32'(frame_done), 32'h1);

      $display("[TB] scenario: blank digit 3");
      sendDigit(3, C_BL);
      checkOutput("s5 char_valid[3]", 32'(char_valid[3]), 32'h0);
      checkOutput("s5 blank_out[3]", 32'(blank_out[3]), 32'h1);
      checkOutput("s5 char_out[7:6]", 32'(char_out[7:6]), 32'h3);

      $display("[TB] scenario: reset mid-frame");
      sendDigit(0, C_H);
      sendDigit(1, C_E);
      sendDigit(2, C_L);
      resetn = 1'b0;
      modelClear();
      scan_valid = 1'b0;
      #1;
      checkOutput("s6 char_out", 32'(char_out), 32'h0);
      checkOutput("s6 char_valid", 32'(char_valid), 32'h0);
      checkOutput("s6 blank_out", 32'(blank_out), 32'h0);
      @(posedge clk);
      #1 resetn = 1'b1;
      frameBase = frameCount;
      sendDigit(3, C_L);
      sendDigit(4, C_O);
      applyStimulus(1'b0, '0, '0, 1);
      checkOutput("s6 frame count", 32'(frameCount - frameBase), 32'h0);
      checkOutput("s6 char_valid", 32'(char_valid), 32'(5'b11000));

      $display("[TB] random traffic");
      d = 0;
      repeat (200) begin
         r = $urandom_range(0, 9);
         if (r < 6) d = (d + 1) % N;
         else d = $urandom_range(0, 7);
         k = $urandom_range(0, 6);
         case (k)
            0: code = C_H;
            1: code = C_E;
            2: code = C_L;
            3: code = C_O;
            4: code = C_BL;
            5: code = 7'($urandom);
            default: code = C_BAD;
         endcase
         if (r == 9) begin
            applyStimulus(1'b1, IW'(d), code, 1);
            applyStimulus(1'b0, IW'(d), code, $urandom_range(1, 2));
            applyStimulus(1'b1, IW'(d), code, 1);
         end else begin
            hold = $urandom_range(1, 3);
            applyStimulus(($urandom_range(0, 7) != 0), IW'(d), code, hold);
         end
      end
      applyStimulus(1'b0, '0, '0, 2);

      checkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("[TB] FAIL watchdog: simulation time limit reached at %0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
